// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative signed multiply/divide sequencer feeding the Hi/Lo registers
// Optional MULDIV_EARLY_OUT_EN: multiply exits once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             hilo_load,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divby0flag
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_sh;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_rem;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_is_div;
  logic               r_divby0;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_last;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_prod;

  assign w_abs_a  = op_a[WIDTH-1] ? -op_a : op_a;
  assign w_abs_b  = op_b[WIDTH-1] ? -op_b : op_b;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  // Shifted remainder never exceeds WIDTH bits, so bit WIDTH of the trial is the borrow.
  assign w_rem_sh = {r_rem, r_q[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_sh[WIDTH-1:0]};
  assign w_prod   = r_neg_lo ? -r_acc : r_acc;

  assign hi = r_hi;
  assign lo = r_lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    hilo_load  = 1'b0;
    divby0flag = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_mult)     w_next = S_MUL;
        else if (start_div) w_next = (op_b == '0) ? S_DONE : S_DIV;
      end
      S_MUL: begin
        busy = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
        if (w_last || (r_q == '0)) w_next = S_FIX;
`else
        if (w_last) w_next = S_FIX;
`endif
      end
      S_DIV: begin
        busy = 1'b1;
        if (w_last) w_next = S_FIX;
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        hilo_load  = ~r_divby0;
        divby0flag = r_divby0;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_sh     <= '0;
      r_q      <= '0;
      r_rem    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_is_div <= 1'b0;
      r_divby0 <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_mult) begin
            r_acc    <= '0;
            r_sh     <= {{WIDTH{1'b0}}, w_abs_a};
            r_q      <= w_abs_b;
            r_neg_lo <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            r_is_div <= 1'b0;
            r_divby0 <= 1'b0;
            r_cnt    <= '0;
          end else if (start_div) begin
            r_rem    <= '0;
            r_q      <= w_abs_a;
            r_sh     <= {{WIDTH{1'b0}}, w_abs_b};
            r_neg_lo <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            r_neg_hi <= op_a[WIDTH-1];
            r_is_div <= 1'b1;
            r_divby0 <= (op_b == '0);
            r_cnt    <= '0;
          end
        end
        // Multiplicand moves left instead of the product moving right, so an
        // early exit leaves the accumulator already aligned.
        S_MUL: begin
          if (r_q[0]) r_acc <= r_acc + r_sh;
          r_sh  <= r_sh << 1;
          r_q   <= r_q >> 1;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DIV: begin
          if (w_trial[WIDTH]) begin
            r_rem <= w_rem_sh[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b0};
          end else begin
            r_rem <= w_trial[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b1};
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          if (r_is_div) begin
            r_lo <= r_neg_lo ? -r_q : r_q;
            r_hi <= r_neg_hi ? -r_rem : r_rem;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_mult, start_div;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, hilo_load, divby0flag;
  logic [W-1:0] hi, lo;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hilo_load(hilo_load),
    .hi(hi), .lo(lo), .divby0flag(divby0flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    logic         is_mult;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    exp_t   e;
    longint sa, sbv, p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.is_mult = m;
    e.dz      = 1'b0;
    if (m) begin
      p    = sa * sbv;
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.lat = W + 2;
    end else if (b == '0) begin
      e.dz = 1'b1;
      e.hi = m_hi;
      e.lo = m_lo;
      e.lat = 1;
    end else begin
      p    = sa / sbv;
      e.lo = p[31:0];
      p    = sa % sbv;
      e.hi = p[31:0];
      e.lat = W + 2;
    end
    if (push) begin
      sb.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end
    @(negedge clk);
    start_mult = m;
    start_div  = d;
    op_a = a;
    op_b = b;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit repulse);
    exp_t e;
    int   k;
    k = 0;
    check({tag, "_busy_t1"}, busy, 1);
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
      if (repulse && k == 2) begin
        start_mult = 1'b1; start_div = 1'b1; op_a = 32'd100; op_b = 32'd7;
      end else begin
        start_mult = 1'b0; start_div = 1'b0;
      end
    end
    start_mult = 1'b0;
    start_div  = 1'b0;
    if (!done) begin
      check({tag, "_timeout"}, 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check({tag, "_hi"}, hi, e.hi);
    check({tag, "_lo"}, lo, e.lo);
    check({tag, "_hilo_load"}, hilo_load, !e.dz);
    check({tag, "_divby0"}, divby0flag, e.dz);
    check({tag, "_busy_done"}, busy, 1);
`ifdef MULDIV_EARLY_OUT_EN
    if (e.is_mult) check({tag, "_lat_le"}, (k + 1 <= e.lat), 1);
    else           check({tag, "_lat"}, k + 1, e.lat);
`else
    check({tag, "_lat"}, k + 1, e.lat);
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic no_done(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check({tag, "_no_done"}, n, 0);
  endtask

  initial begin
    reset = 1'b0; start_mult = 1'b0; start_div = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo_load", hilo_load, 0);
    check("rst_divby0", divby0flag, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b1;

    issue(1, 0, 32'd7, -32'sd3, 1);           wait_done("mul_7_m3", 0);
    issue(0, 1, -32'sd7, 32'd2, 1);           wait_done("div_m7_2", 0);
    issue(0, 1, 32'd5, 32'd0, 1);             wait_done("div_by0", 0);
    issue(1, 1, 32'd3, 32'd4, 1);             wait_done("both_3_4", 1);
    no_done("after_repulse", 40);

    issue(0, 1, -32'sd100, 32'd7, 0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    no_done("after_abort", 40);
    issue(0, 1, 32'd100, 32'd7, 1);           wait_done("div_100_7", 0);

    issue(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done("mul_min_m1", 0);
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done("div_min_m1", 0);
    issue(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1); wait_done("mul_max_max", 0);
    issue(1, 0, 32'd123456, -32'sd654321, 1);     wait_done("mul_mixed", 0);
    issue(0, 1, -32'sd100, -32'sd7, 1);           wait_done("div_neg_neg", 0);
    issue(0, 1, 32'd7, -32'sd100, 1);             wait_done("div_small", 0);
    issue(1, 0, 32'd5, 32'd1, 1);                 wait_done("mul_5_1", 0);
    issue(1, 0, 32'h1234_5678, 32'd0, 1);         wait_done("mul_by0", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
